// File: rtl/wide_add_seq.sv
// Sequential W-bit adder/subtractor built on one time-shared 4-bit slice.
// One nibble per cycle, carry chained through a register, start/ready/done handshake.
module wide_add_seq #(
    parameter int NSLICE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*NSLICE-1:0]   a,
    input  logic [4*NSLICE-1:0]   b,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*NSLICE-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);
    localparam int W  = 4 * NSLICE;
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [W-1:0]    op_a, op_b, work, work_next;
    logic            op_sub, carry;
    logic [KW-1:0]   k;
    logic [KW+1:0]   bit_idx;
    logic [W-1:0]    a_sh, b_sh;
    logic            slice_cin;
    logic [4:0]      slice_res;
    logic            last;

    // State register only; all decoding lives in the combinational block.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Slice datapath: select nibble k by shifting, add, and merge back into the work word.
    always_comb begin
        bit_idx   = {k, 2'b00};
        a_sh      = op_a >> bit_idx;
        b_sh      = op_b >> bit_idx;
        slice_cin = (k == '0) ? op_sub : carry;
        slice_res = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, slice_cin};
        work_next = (work & ~(W'(4'hF) << bit_idx)) | (W'(slice_res[3:0]) << bit_idx);
        last      = (k == K_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            op_sub <= 1'b0;
            work   <= '0;
            carry  <= 1'b0;
            k      <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a   <= a;
                        op_b   <= sub ? ~b : b;
                        op_sub <= sub;
                        work   <= '0;
                        carry  <= 1'b0;
                        k      <= '0;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    carry <= slice_res[4];
                    if (last) begin
                        k    <= '0;
                        sum  <= work_next;
                        cout <= slice_res[4];
                        ovf  <= (op_a[W-1] == op_b[W-1]) && (work_next[W-1] != op_a[W-1]);
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
